// File: rtl/probe_capture_buffer.sv
// Multi-channel probe capture engine: samples NUM_CH probe channels plus the
// emulation timestamp on a decimation schedule, stores whole frames in a
// DEPTH-frame FIFO and serialises each frame one channel per beat.
module probe_capture_buffer #(
  parameter int NUM_CH     = 8,
  parameter int WIDTH      = 25,
  parameter int TIME_WIDTH = 64,
  parameter int DEC_WIDTH  = 24,
  parameter int DEPTH      = 64,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int FILL_W    = PTR_W + 1
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst,
  input  logic [NUM_CH*WIDTH-1:0] probe_in,
  input  logic [TIME_WIDTH-1:0]   emu_time,
  input  logic [DEC_WIDTH-1:0]    emu_dec_thr,
  input  logic [TIME_WIDTH-1:0]   start_time,
  input  logic                    mode,
  input  logic                    arm,
  input  logic                    disarm,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic [TIME_WIDTH-1:0]   out_time,
  output logic                    out_last,
  output logic [1:0]              state,
  output logic [FILL_W-1:0]       fill_count,
  output logic [15:0]             overflow_cnt
);

  localparam int FRAME_W = TIME_WIDTH + NUM_CH * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e               state_q;
  logic                 mode_q;      // 1 = one-shot, latched on arm
  logic [DEC_WIDTH-1:0] dec_cnt;
  logic [FRAME_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  logic                 sample_fire;
  logic                 beat_accept;
  logic                 pop;
  logic                 has_room;
  logic                 wr_en;
  logic                 drop;
  logic [FILL_W-1:0]    fill_next;
  logic                 oneshot_full;

  logic                 ser_load;
  logic [PTR_W-1:0]     load_ptr;
  logic [CH_W-1:0]      load_ch;
  logic [FRAME_W-1:0]   load_frame;
  logic [WIDTH-1:0]     load_data;

  assign state = state_q;

  // Sample scheduling, FIFO admission and one-shot completion decode.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    sample_fire  = ((state_q == S_WAIT) && (emu_time >= start_time)) ||
                   ((state_q == S_CAPTURE) && (dec_cnt >= emu_dec_thr));
    beat_accept  = out_valid && out_ready;
    pop          = beat_accept && out_last;
    // A full FIFO still admits a sample when the head frame leaves this cycle.
    has_room     = (fill_count != FILL_W'(DEPTH)) || pop;
    wr_en        = sample_fire && has_room && !clear;
    drop         = sample_fire && !has_room && !clear;
    fill_next    = fill_count;
    if (wr_en && !pop)      fill_next = fill_count + FILL_W'(1);
    else if (!wr_en && pop) fill_next = fill_count - FILL_W'(1);
    // One-shot ends once a sample leaves the FIFO with no free slot.
    oneshot_full = mode_q && ((wr_en && (fill_next == FILL_W'(DEPTH))) || drop);
  end

  // Capture FSM and decimation counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      dec_cnt <= '0;
    end else begin
      if (sample_fire)              dec_cnt <= '0;
      else if (state_q == S_CAPTURE) dec_cnt <= dec_cnt + DEC_WIDTH'(1);

      if (disarm) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (arm) begin
              state_q <= S_WAIT;
              mode_q  <= mode;
              dec_cnt <= '0;
            end
          end
          S_WAIT: begin
            if (sample_fire) state_q <= oneshot_full ? S_DONE : S_CAPTURE;
          end
          S_CAPTURE: begin
            if (oneshot_full) state_q <= S_DONE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // FIFO pointers, occupancy and the saturating stream-mode drop counter.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_count   <= '0;
      overflow_cnt <= '0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_count   <= '0;
      overflow_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      fill_count <= fill_next;
      if (drop && !mode_q && (overflow_cnt != 16'hFFFF))
        overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  // Frame storage.
  // NOTE: the frame array has no reset; validity is tracked entirely by the
  // pointers and fill_count, so stale contents are never presented.
  always_ff @(posedge emu_clk) begin
    if (wr_en) mem[wr_ptr] <= {emu_time, probe_in};
  end

  // Choose which frame/channel the output stage loads next.
  always_comb begin
    ser_load = 1'b0;
    load_ptr = rd_ptr;
    load_ch  = '0;
    if (beat_accept && !out_last) begin
      ser_load = 1'b1;
      load_ch  = out_ch + CH_W'(1);
    end else if (beat_accept && out_last) begin
      // Continue straight into the next stored frame with no bubble.
      if (fill_count > FILL_W'(1)) begin
        ser_load = 1'b1;
        load_ptr = rd_ptr + PTR_W'(1);
      end
    end else if (!out_valid && (fill_count != '0)) begin
      ser_load = 1'b1;
    end
  end

  // Channel extraction from the selected frame.
  always_comb begin
    load_frame = mem[load_ptr];
    load_data  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (load_ch == CH_W'(k)) load_data = load_frame[k*WIDTH +: WIDTH];
    end
  end

  // Registered output stage; holds the beat while the consumer stalls.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_time  <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else if (ser_load) begin
      out_valid <= 1'b1;
      out_ch    <= load_ch;
      out_data  <= load_data;
      out_time  <= load_frame[FRAME_W-1 -: TIME_WIDTH];
      out_last  <= (load_ch == CH_W'(NUM_CH - 1));
    end else if (beat_accept) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_probe_capture_buffer.sv
// Self-checking bench for probe_capture_buffer: directed scenarios with random
// probe data, compared every cycle against a queue-based frame model.
module tb_probe_capture_buffer;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 25;
  localparam int TW     = 64;
  localparam int DW     = 8;
  localparam int DEPTH  = 8;
  localparam int CH_W   = 2;
  localparam int FILL_W = 4;

  localparam int S_IDLE = 0, S_WAIT = 1, S_CAPTURE = 2, S_DONE = 3;

  logic                    emu_clk = 1'b0;
  logic                    emu_rst;
  logic [NUM_CH*WIDTH-1:0] probe_in;
  logic [TW-1:0]           emu_time;
  logic [DW-1:0]           emu_dec_thr;
  logic [TW-1:0]           start_time;
  logic                    mode, arm, disarm, clear, out_ready;
  logic                    out_valid, out_last;
  logic [WIDTH-1:0]        out_data;
  logic [CH_W-1:0]         out_ch;
  logic [TW-1:0]           out_time;
  logic [1:0]              state;
  logic [FILL_W-1:0]       fill_count;
  logic [15:0]             overflow_cnt;

  probe_capture_buffer #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .TIME_WIDTH(TW), .DEC_WIDTH(DW), .DEPTH(DEPTH)
  ) dut (
    .emu_clk(emu_clk), .emu_rst(emu_rst), .probe_in(probe_in), .emu_time(emu_time),
    .emu_dec_thr(emu_dec_thr), .start_time(start_time), .mode(mode), .arm(arm),
    .disarm(disarm), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_time(out_time), .out_last(out_last),
    .state(state), .fill_count(fill_count), .overflow_cnt(overflow_cnt)
  );

  always #5 emu_clk = ~emu_clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  longint        cyc = 0;
  logic [TW-1:0] time_step = 64'd1;

  // Reference model: stored frames as a queue, sampling by elapsed cycles.
  typedef struct {
    logic [TW-1:0]           t;
    logic [NUM_CH*WIDTH-1:0] p;
  } frame_t;

  frame_t m_q[$];
  int     m_state;
  bit     m_mode;
  longint m_last;
  int     m_ovf;
  bit     m_pres;
  int     m_beat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state = S_IDLE;
    m_mode  = 1'b0;
    m_last  = 0;
    m_ovf   = 0;
    m_pres  = 1'b0;
    m_beat  = 0;
  endtask

  function automatic bit sample_due();
    return ((m_state == S_WAIT) && (emu_time >= start_time)) ||
           ((m_state == S_CAPTURE) && ((cyc - m_last) > longint'(emu_dec_thr)));
  endfunction

  // Advance the model by one clock edge using the inputs now being driven.
  task automatic model_step();
    int     n, popi;
    bit     accept, last, pop, samp, room;
    frame_t f;
    n      = m_q.size();
    accept = m_pres && out_ready;
    last   = (m_beat == NUM_CH - 1);
    pop    = accept && last;
    popi   = pop ? 1 : 0;
    samp   = sample_due();
    room   = (n - popi) < DEPTH;
    if (samp) m_last = cyc;

    if (disarm) m_state = S_IDLE;
    else if (arm && (m_state == S_IDLE || m_state == S_DONE)) begin
      m_state = S_WAIT;
      m_mode  = mode;
    end else if (samp && !clear && m_mode && ((n - popi + (room ? 1 : 0)) == DEPTH))
      m_state = S_DONE;
    else if (samp && m_state == S_WAIT)
      m_state = S_CAPTURE;

    if (clear) begin
      m_pres = 1'b0;
      m_beat = 0;
    end else if (accept && !last) m_beat++;
    else if (pop) begin
      m_pres = (n > 1);
      m_beat = 0;
    end else if (!m_pres && n > 0) begin
      m_pres = 1'b1;
      m_beat = 0;
    end

    if (clear) begin
      m_q.delete();
      m_ovf = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (samp) begin
        if (room) begin
          f.t = emu_time;
          f.p = probe_in;
          m_q.push_back(f);
        end else if (!m_mode && m_ovf < 65535) m_ovf++;
      end
    end
  endtask

  task automatic compare_all();
    frame_t f;
    check("state", state, m_state);
    check("fill_count", fill_count, m_q.size());
    check("overflow_cnt", overflow_cnt, m_ovf);
    check("out_valid", out_valid, m_pres);
    if (m_pres) begin
      f = m_q[0];
      check("out_ch", out_ch, m_beat);
      check("out_data", out_data, f.p[m_beat*WIDTH +: WIDTH]);
      check("out_time", out_time, f.t);
      check("out_last", out_last, m_beat == NUM_CH - 1);
    end
  endtask

  task automatic new_probes();
    for (int k = 0; k < NUM_CH; k++) probe_in[k*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  // One clock: model, edge, compare 1 ns later, then move time and probes.
  task automatic tick();
    model_step();
    @(posedge emu_clk);
    #1;
    cyc++;
    compare_all();
    emu_time = emu_time + time_step;
    new_probes();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_arm(input bit m);
    mode = m;
    arm  = 1'b1;
    tick();
    arm  = 1'b0;
  endtask

  task automatic wait_fill(input int target, input int budget);
    for (int k = 0; k < budget && m_q.size() != target; k++) tick();
    check("wait_fill", fill_count, target);
  endtask

  task automatic drain(input bit stop);
    if (stop) begin
      disarm = 1'b1;
      tick();
      disarm = 1'b0;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 100 && (m_q.size() != 0 || m_pres); k++) tick();
    tick();
    check("drained_valid", out_valid, 1'b0);
    check("drained_fill", fill_count, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state, S_IDLE);
    check({tag, "_fill"}, fill_count, 0);
    check({tag, "_ovf"}, overflow_cnt, 0);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_ch"}, out_ch, 0);
    check({tag, "_time"}, out_time, 0);
    check({tag, "_last"}, out_last, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    emu_rst = 1'b1; probe_in = '0; emu_time = '0; emu_dec_thr = '0; start_time = '0;
    mode = 1'b0; arm = 1'b0; disarm = 1'b0; clear = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge emu_clk);
    emu_rst = 1'b0;
    new_probes();

    // Stream every cycle, drain at a quarter of the sample rate.
    time_step = 64'd10; emu_dec_thr = 8'd0; start_time = '0; out_ready = 1'b1;
    do_arm(1'b0);
    for (int k = 0; k < 80; k++) tick();
    check("t1_state", state, S_CAPTURE);
    check("t1_ovf_counting", overflow_cnt != 16'd0, 1'b1);
    drain(1'b1);

    // Delayed start with decimation by 10.
    pulse_clear();
    emu_time = 64'd990; time_step = 64'd1; emu_dec_thr = 8'd9; start_time = 64'd1000;
    out_ready = 1'b1;
    do_arm(1'b0);
    for (int k = 0; k < 5; k++) tick();
    check("t2_waiting", state, S_WAIT);
    for (int k = 0; k < 60; k++) tick();
    drain(1'b1);

    // One-shot fills exactly DEPTH frames with the consumer stalled.
    pulse_clear();
    out_ready = 1'b0; emu_dec_thr = 8'd0; start_time = '0;
    do_arm(1'b1);
    for (int k = 0; k < 15; k++) tick();
    check("t3_state_done", state, S_DONE);
    check("t3_fill_full", fill_count, DEPTH);
    drain(1'b0);

    // Full FIFO: last-beat pop coincides with a sample, then a pure drop.
    pulse_clear();
    out_ready = 1'b0; emu_dec_thr = 8'd9;
    do_arm(1'b0);
    wait_fill(DEPTH, 200);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && m_beat != NUM_CH - 1; k++) tick();
    out_ready = 1'b0;
    for (int k = 0; k < 20 && !sample_due(); k++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_fill_kept", fill_count, DEPTH);
    check("t4_no_overflow", overflow_cnt, 0);
    for (int k = 0; k < 20 && !sample_due(); k++) tick();
    tick();
    check("t4_overflow_one", overflow_cnt, 1);
    drain(1'b1);

    // Random back-pressure and probe data against the reference queue.
    pulse_clear();
    emu_dec_thr = DW'($urandom_range(0, 3));
    start_time  = emu_time + 64'd5;
    do_arm(1'b0);
    for (int k = 0; k < 400; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) emu_dec_thr = DW'($urandom_range(0, 3));
      tick();
    end
    drain(1'b1);

    // Asynchronous reset mid-capture, then a clean restart.
    pulse_clear();
    out_ready = 1'b0; emu_dec_thr = 8'd9; start_time = '0;
    do_arm(1'b0);
    wait_fill(3, 100);
    #2;
    emu_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge emu_clk);
    emu_rst = 1'b0;
    out_ready = 1'b1;
    do_arm(1'b0);
    for (int k = 0; k < 40; k++) tick();

    // Clear with stored frames.
    out_ready = 1'b0;
    wait_fill(5, 100);
    pulse_clear();
    check("clr_fill", fill_count, 0);
    check("clr_valid", out_valid, 1'b0);
    check("clr_state_kept", state, S_CAPTURE);
    drain(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
